// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MAR/MDR memory access controller.
// Size encodings, FSM states and the size-to-byte-count helper.
package mem_access_ctrl_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Sign/zero extension of an assembled load value by access size.
// Size 11 behaves as a word.
module mem_load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  size,
  input  logic        sgn,
  output logic [31:0] ext
);

  always_comb begin
    ext = raw;
    unique case (1'b1)
      (size == SZ_BYTE): ext = {{24{sgn & raw[7]}}, raw[7:0]};
      (size == SZ_HALF): ext = {{16{sgn & raw[15]}}, raw[15:0]};
      default:           ext = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Multi-cycle byte-serial memory access controller, MOV/MOC handshake.
// Optional misalignment trap: define ALIGN_CHECK_EN to add the Err port.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int BYTE_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              MOV,
  input  logic              RW,
  input  logic [1:0]        Size,
  input  logic              Sgn,
  input  logic [31:0]       Addr,
  input  logic [31:0]       WData,
  output logic              MOC,
  output logic [31:0]       DataOut,
`ifdef ALIGN_CHECK_EN
  output logic              Err,
`endif
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  localparam int CW = (BYTE_CYCLES > 1) ? $clog2(BYTE_CYCLES) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(BYTE_CYCLES - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] base, base_n;
  logic [31:0]       wd, wd_n;
  logic [31:0]       asm_q, asm_n;
  logic              rw, rw_n;
  logic              sgn, sgn_n;
  logic [1:0]        sz, sz_n;
  logic [2:0]        nb, nb_n;
  logic [1:0]        idx, idx_n;
  logic [CW-1:0]     cyc, cyc_n;
  logic              dout_ld;
  logic              leave;
  logic [1:0]        rpos, wpos;
  logic [7:0]        wbyte;
  logic [31:0]       ext;
  logic              unused_addr;

  assign unused_addr = ^Addr[31:ADDR_W];
  assign leave = (state == DONE) && MOC && !MOV;
  assign rpos  = 2'(nb - 3'd1 - {1'b0, idx});
  assign wpos  = 2'(nb_n - 3'd1 - {1'b0, idx_n});
  assign wbyte = wd_n[{wpos, 3'b000} +: 8];

`ifdef ALIGN_CHECK_EN
  logic mis;
  logic err_set;
  assign mis = ((Size == SZ_HALF) && Addr[0]) ||
               (Size[1] && (Addr[1:0] != 2'b00));
`endif

  mem_load_extend u_ext (
    .raw  (asm_n),
    .size (sz),
    .sgn  (sgn),
    .ext  (ext)
  );

  always_comb begin
    state_n = state;
    base_n  = base;
    wd_n    = wd;
    asm_n   = asm_q;
    rw_n    = rw;
    sgn_n   = sgn;
    sz_n    = sz;
    nb_n    = nb;
    idx_n   = idx;
    cyc_n   = cyc;
    dout_ld = 1'b0;
`ifdef ALIGN_CHECK_EN
    err_set = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (MOV) begin
          base_n = Addr[ADDR_W-1:0];
          wd_n   = WData;
          rw_n   = RW;
          sgn_n  = Sgn;
          sz_n   = Size;
          nb_n   = size_bytes(Size);
          idx_n  = 2'd0;
          cyc_n  = '0;
          asm_n  = '0;
`ifdef ALIGN_CHECK_EN
          if (mis) begin
            state_n = DONE;
            err_set = 1'b1;
          end else begin
            state_n = XFER;
          end
`else
          state_n = XFER;
`endif
        end
      end
      XFER: begin
        if (cyc == CYC_LAST) begin
          cyc_n = '0;
          if (rw) asm_n[{rpos, 3'b000} +: 8] = mem_rdata;
          if ({1'b0, idx} == nb - 3'd1) begin
            state_n = DONE;
            dout_ld = rw;
          end else begin
            idx_n = idx + 2'd1;
          end
        end else begin
          cyc_n = cyc + CW'(1);
        end
      end
      DONE: begin
        if (leave) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state     <= IDLE;
      base      <= '0;
      wd        <= '0;
      asm_q     <= '0;
      rw        <= 1'b0;
      sgn       <= 1'b0;
      sz        <= SZ_BYTE;
      nb        <= 3'd1;
      idx       <= 2'd0;
      cyc       <= '0;
      MOC       <= 1'b0;
      DataOut   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_n;
      base   <= base_n;
      wd     <= wd_n;
      asm_q  <= asm_n;
      rw     <= rw_n;
      sgn    <= sgn_n;
      sz     <= sz_n;
      nb     <= nb_n;
      idx    <= idx_n;
      cyc    <= cyc_n;
      // MOC lags DONE entry by a cycle so it always pulses once
      MOC    <= (state == DONE) && !leave;
      mem_en <= (state_n == XFER);
      mem_we <= (state_n == XFER) && !rw_n;
      if (state_n == XFER) begin
        mem_addr  <= base_n + ADDR_W'(idx_n);
        mem_wdata <= wbyte;
      end
      if (dout_ld) DataOut <= ext;
    end
  end

`ifdef ALIGN_CHECK_EN
  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      Err <= 1'b0;
    end else if (err_set) begin
      Err <= 1'b1;
    end else if (leave) begin
      Err <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl with a byte-array model.
// Random loads/stores plus directed wrap, extend, hold and reset cases.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  localparam int AW    = 9;
  localparam int BC    = 2;
  localparam int DEPTH = 512;

  logic          Clk = 1'b0;
  logic          Clr = 1'b0;
  logic          MOV = 1'b0;
  logic          RW = 1'b0;
  logic [1:0]    Size = 2'b00;
  logic          Sgn = 1'b0;
  logic [31:0]   Addr = 32'h0;
  logic [31:0]   WData = 32'h0;
  logic          MOC;
  logic [31:0]   DataOut;
`ifdef ALIGN_CHECK_EN
  logic          Err;
`endif
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.ADDR_W(AW), .BYTE_CYCLES(BC)) dut (
    .Clk       (Clk),
    .Clr       (Clr),
    .MOV       (MOV),
    .RW        (RW),
    .Size      (Size),
    .Sgn       (Sgn),
    .Addr      (Addr),
    .WData     (WData),
    .MOC       (MOC),
    .DataOut   (DataOut),
`ifdef ALIGN_CHECK_EN
    .Err       (Err),
`endif
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [7:0] arr     [DEPTH];
  logic [7:0] ref_mem [DEPTH];
  logic       load_img = 1'b0;

  assign mem_rdata = arr[mem_addr];

  always @(posedge Clk) begin
    if (load_img) begin
      for (int i = 0; i < DEPTH; i++) arr[i] <= ref_mem[i];
    end else if (mem_en && mem_we) begin
      arr[mem_addr] <= mem_wdata;
    end
  end

  typedef struct {
    logic          rw;
    int            n;
    logic [AW-1:0] addr;
    logic [31:0]   dout;
    logic [31:0]   wbytes;
    int            t_issue;
    int            lat;
    logic          err;
  } exp_t;

  exp_t        sbq[$];
  int          total = 0;
  int          bad = 0;
  int          cyc_cnt = 0;
  logic [31:0] last_dout = 32'h0;

  always @(posedge Clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: every rising MOC retires one scoreboard entry
  logic        moc_prev = 1'b0;
  exp_t        me;
  logic [31:0] mgot;

  always @(negedge Clk) begin
    if (MOC && !moc_prev) begin
      if (sbq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_moc got=1 exp=0 t=%0t", $time);
      end else begin
        me = sbq.pop_front();
        chk("latency", 32'(cyc_cnt - me.t_issue), 32'(me.lat));
        chk("dataout", DataOut, me.dout);
`ifdef ALIGN_CHECK_EN
        chk("err", {31'b0, Err}, {31'b0, me.err});
`endif
        if (!me.rw && !me.err) begin
          mgot = 32'h0;
          for (int i = 0; i < me.n; i++)
            mgot = (mgot << 8) | 32'(arr[(int'(me.addr) + i) % DEPTH]);
          chk("store_bytes", mgot, me.wbytes);
        end
      end
    end
    moc_prev <= MOC;
  end

  function automatic int nbytes(input logic [1:0] s);
    if (s == 2'b00) return 1;
    if (s == 2'b01) return 2;
    return 4;
  endfunction

  task automatic access(input logic rw, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a,
                        input logic [31:0] wd);
    exp_t        e;
    int          n;
    int          hold;
    logic [31:0] v;
    bit          ok;
    n = nbytes(sz);
    e.rw = rw;
    e.n = n;
    e.addr = a[AW-1:0];
    e.err = 1'b0;
    e.wbytes = 32'h0;
`ifdef ALIGN_CHECK_EN
    if ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00)) e.err = 1'b1;
`endif
    e.lat = e.err ? 1 : 1 + n * BC;
    if (!e.err) begin
      if (rw) begin
        v = 32'h0;
        for (int i = 0; i < n; i++)
          v = (v << 8) | 32'(ref_mem[(int'(e.addr) + i) % DEPTH]);
        if (sg && n == 1 && v[7])  v = v | 32'hFFFFFF00;
        if (sg && n == 2 && v[15]) v = v | 32'hFFFF0000;
        last_dout = v;
      end else begin
        for (int i = 0; i < n; i++)
          ref_mem[(int'(e.addr) + i) % DEPTH] = 8'(wd >> (8 * (n - 1 - i)));
        e.wbytes = (n == 4) ? wd : (wd & ((32'd1 << (8 * n)) - 32'd1));
      end
    end
    e.dout = last_dout;
    @(negedge Clk);
    e.t_issue = cyc_cnt + 1;
    sbq.push_back(e);
    MOV = 1'b1;
    RW = rw;
    Size = sz;
    Sgn = sg;
    Addr = a;
    WData = wd;
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge Clk);
      if (MOC) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL moc_timeout got=0 exp=1 t=%0t", $time);
    end
    hold = $urandom_range(0, 5);
    for (int j = 0; j < hold; j++) begin
      @(negedge Clk);
      chk("moc_hold", {31'b0, MOC}, 32'h1);
      chk("no_reaccess", {31'b0, mem_en}, 32'h0);
    end
    MOV = 1'b0;
    RW = 1'($urandom);
    Addr = $urandom;
    @(negedge Clk);
    chk("moc_fall", {31'b0, MOC}, 32'h0);
    repeat ($urandom_range(0, 3)) @(negedge Clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'($urandom);
    load_img = 1'b1;
    repeat (2) @(negedge Clk);
    load_img = 1'b0;
    chk("rst_moc", {31'b0, MOC}, 32'h0);
    chk("rst_en", {31'b0, mem_en}, 32'h0);
    chk("rst_we", {31'b0, mem_we}, 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_dout", DataOut, 32'h0);
    Clr = 1'b1;
    repeat (20) begin
      @(negedge Clk);
      chk("idle_moc", {31'b0, MOC}, 32'h0);
      chk("idle_en", {31'b0, mem_en}, 32'h0);
      chk("idle_dout", DataOut, 32'h0);
    end

    access(1'b0, SZ_WORD, 1'b0, 32'h010, 32'hDEADBEEF);
    access(1'b0, SZ_BYTE, 1'b0, 32'h011, 32'h00000080);
    access(1'b1, SZ_BYTE, 1'b1, 32'h011, 32'h0);
    chk("ld_byte_sgn", DataOut, 32'hFFFFFF80);
    access(1'b1, SZ_BYTE, 1'b0, 32'h011, 32'h0);
    chk("ld_byte_zero", DataOut, 32'h00000080);
    access(1'b0, SZ_BYTE, 1'b0, 32'h1FF, 32'h0000009A);
    access(1'b0, SZ_BYTE, 1'b0, 32'h000, 32'h0000003C);
    access(1'b1, SZ_HALF, 1'b1, 32'h1FF, 32'h0);
    chk("ld_half_wrap", DataOut, 32'hFFFF9A3C);
    access(1'b1, SZ_WORD, 1'b0, 32'h010, 32'h0);
    chk("ld_word", DataOut, 32'hDE80BEEF);
    access(1'b1, SZ_WORD, 1'b0, 32'h006, 32'h0);

    for (int k = 0; k < 60; k++)
      access(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom);

    @(negedge Clk);
    MOV = 1'b1;
    RW = 1'b0;
    Size = SZ_WORD;
    Addr = 32'h100;
    WData = 32'h12345678;
    repeat (3) @(negedge Clk);
    chk("pre_rst_we", {31'b0, mem_we}, 32'h1);
    #2;
    Clr = 1'b0;
    #1;
    chk("mid_rst_we", {31'b0, mem_we}, 32'h0);
    chk("mid_rst_en", {31'b0, mem_en}, 32'h0);
    chk("mid_rst_moc", {31'b0, MOC}, 32'h0);
    MOV = 1'b0;
    @(negedge Clk);
    Clr = 1'b1;
    last_dout = 32'h0;
    chk("post_rst_dout", DataOut, 32'h0);
    repeat (2) @(negedge Clk);
    access(1'b1, SZ_WORD, 1'b0, 32'h010, 32'h0);

    repeat (3) @(negedge Clk);
    chk("sb_empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Multi-cycle memory access controller between the datapath's MAR/MDR registers and a byte-wide 512x8 storage array. It accepts one load or store per MOV/MOC four-phase handshake. Each access is split into 1, 2 or 4 sequential byte cycles in big-endian order, and load results are sign- or zero-extended to 32 bits. It replaces direct datapath-to-array wiring, so memory latency is a parameter instead of zero.

## Interface
- ADDR_W, 9: byte address width; the array holds 2^ADDR_W bytes.
- BYTE_CYCLES, 2: cycles per byte transfer, minimum 1. Read data is sampled on the last cycle.

- Clk  in  1  clock, rising edge.
- Clr  in  1  asynchronous, active-low reset.
- MOV  in  1  memory operation valid, from the control unit.
- RW  in  1  1 = read (load), 0 = write (store).
- Size  in  2  00 = byte, 01 = halfword, 10 = word. 11 is treated as word.
- Sgn  in  1  1 = sign-extend loads, 0 = zero-extend.
- Addr  in  32  byte address from MAR_out. Only [ADDR_W-1:0] is used.
- WData  in  32  store data from MDR_out, right-justified.
- MOC  out  1  memory operation complete.
- DataOut  out  32  load result, extended.
- Err  out  1  misaligned access flag. Only present with ALIGN_CHECK_EN.
- mem_en  out  1  array enable.
- mem_we  out  1  array write enable.
- mem_addr  out  ADDR_W  array byte address.
- mem_wdata  out  8  array write byte.
- mem_rdata  in  8  array read byte, combinational from mem_addr.

## Operation
- States: IDLE, XFER, DONE.
- IDLE:
  - MOV=1 latches Addr, WData, RW, Size and Sgn.
  - Loads byte count N (1/2/4), byte_idx=0 and cyc=0.
  - Moves to XFER.
- XFER:
  - mem_en=1, mem_addr = (base + byte_idx) mod 2^ADDR_W, so addresses wrap at the top of the array.
  - mem_we = ~RW.
  - mem_wdata = byte (N-1-byte_idx) of WData, counting from the LSB. The lowest address receives the most significant byte.
  - cyc counts 0..BYTE_CYCLES-1.
  - On the last cycle of a read, mem_rdata shifts into the assembly register at its big-endian position.
  - After byte N-1 completes, moves to DONE.
- DONE:
  - MOC=1.
  - DataOut is updated on entry, for reads only: byte N-1 is the MSB of the assembled value, and bits above it are extended by Sgn.
  - Stays in DONE while MOV=1. Moves to IDLE when MOV=0.
- MOV changes during XFER are ignored; the access always completes.
- DataOut holds its value across writes and idle periods.
- A new request needs MOV low for at least one cycle after MOC, because of the four-phase handshake.

## Timing
- Reset values: state IDLE; MOC, mem_en and mem_we all 0; mem_addr, mem_wdata, DataOut and Err all 0.
- Reset mid-XFER returns to IDLE and drops mem_we immediately. Bytes already written stay written; no rollback.
- Latency: MOV sampled at edge T, so MOC rises after edge T + 1 + N·BYTE_CYCLES.
  - Example: word load with BYTE_CYCLES=2 → MOC high 9 cycles after MOV is sampled.
- MOC falls on the edge after MOV is sampled low.
- mem_en and mem_we are registered outputs, active only in XFER.

## Configuration
- ALIGN_CHECK_EN:
  - Defined: a halfword with Addr[0]=1, or a word with Addr[1:0]≠0, skips XFER.
  - In that case the controller goes IDLE→DONE in one cycle with Err=1, no array cycle, and DataOut unchanged.
  - Err clears when leaving DONE.
- Not defined: no Err port. Misaligned accesses proceed byte-sequentially from the given address.

## Structure
- Shared package holds:
  - Size encodings (SZ_BYTE, SZ_HALF, SZ_WORD);
  - the state enum;
  - a function mapping Size to byte count.
- One sub-module, mem_load_extend: combinational sign/zero extension of the assembled value by Size and Sgn.

## Test plan
- Reset then idle → MOC=0, mem_en=0, DataOut=0; no array activity for 20 cycles.
- Store word 0xDEADBEEF at 0x010 → bytes DE, AD, BE, EF land at 0x010–0x013; MOC after 9 cycles.
- Load byte 0x80 from 0x011 with Sgn=1 → DataOut=0xFFFFFF80. With Sgn=0 → 0x00000080.
- Load halfword at 0x1FF → reads bytes at 0x1FF then 0x000 (wraparound); DataOut = {ext, mem[0x1FF], mem[0x000]}.
- MOV held high for 5 extra cycles after MOC → MOC stays high and no second access starts. Dropping then raising MOV starts a fresh access.
- With ALIGN_CHECK_EN: word load at 0x006 → Err=1 and MOC high 1 cycle after MOV, mem_en never asserted. Without ALIGN_CHECK_EN: Clr pulled low mid word store → state IDLE and mem_we=0 immediately.
